// File: rtl/interp_scheduler.sv
// interp_scheduler: queues window descriptors and launches the interpolation engine one job at a time.
// Define INTERP_SCHED_TIMEOUT_EN to compile in the RUN-state watchdog (ABORT path).
module interp_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int PIX_PER_JOB = 256,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                        clk,
  input  logic                        RST,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [5:0]                  job_h0,
  input  logic [5:0]                  job_v0,
  input  logic [3:0]                  job_sw,
  input  logic [3:0]                  job_sh,
  output logic                        job_err,
  output logic                        START,
  output logic [5:0]                  H0,
  output logic [5:0]                  V0,
  output logic [3:0]                  SW,
  output logic [3:0]                  SH,
  input  logic                        O_VALID,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  done_id,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
  output logic                        timeout,
  output logic                        eng_abort
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(PIX_PER_JOB) + 1;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PIX_LAST = PW'(PIX_PER_JOB - 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, ABORT} state_t;
  state_t state_q, state_d;
  logic [21:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic [1:0] tag_q, cur_q;
  logic [19:0] par_q;
  logic [PW-1:0] pix_q, pix_d;
  logic job_err_q, hs, ok, push, pop;
  assign job_ready = cnt_q != FULL;
  // 7-bit sums so a window hitting the 64-pixel edge exactly is still legal
  assign ok = (job_sw != 4'd0) && (job_sh != 4'd0) &&
              ({1'b0, job_h0} + {3'b0, job_sw} <= 7'd64) &&
              ({1'b0, job_v0} + {3'b0, job_sh} <= 7'd64);
  assign hs   = job_valid && job_ready;
  assign push = hs && ok;
  assign pop  = (state_q == IDLE) && (cnt_q != '0);
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= {tag_q, job_h0, job_v0, job_sw, job_sh};
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      tag_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (push) tag_q <= tag_q + 2'd1;
      if (pop) rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
`ifdef INTERP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] wdog_q, wdog_d;
  always_ff @(posedge clk or posedge RST)
    if (RST) wdog_q <= '0;
    else wdog_q <= wdog_d;
  assign timeout   = state_q == ABORT;
  assign eng_abort = state_q == ABORT;
`else
  assign timeout   = 1'b0;
  assign eng_abort = 1'b0;
`endif
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      state_q   <= IDLE;
      pix_q     <= '0;
      par_q     <= '0;
      cur_q     <= '0;
      job_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      job_err_q <= hs && !ok;
      if (pop) {cur_q, par_q} <= mem[rd_q];
    end
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
`ifdef INTERP_SCHED_TIMEOUT_EN
    wdog_d  = wdog_q;
`endif
    case (state_q)
      IDLE:   state_d = (cnt_q != '0) ? LAUNCH : IDLE;
      LAUNCH: begin
        pix_d   = '0;
        state_d = RUN;
`ifdef INTERP_SCHED_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      RUN: begin
        if (O_VALID) pix_d = pix_q + PW'(1);
        if (O_VALID && pix_q == PIX_LAST) state_d = DONE;
`ifdef INTERP_SCHED_TIMEOUT_EN
        wdog_d = O_VALID ? '0 : wdog_q + TW'(1);
        if (!O_VALID && wdog_q == TO_LAST) state_d = ABORT;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  assign {H0, V0, SW, SH} = par_q;
  assign START   = state_q == LAUNCH;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign done_id = done ? cur_q : 2'd0;
  assign job_err = job_err_q;
  assign fifo_cnt = cnt_q;
endmodule

// File: tb/tb_interp_scheduler.sv
// tb_interp_scheduler: directed self-checking bench for interp_scheduler (default parameters).
module tb_interp_scheduler;
  logic clk = 1'b0, RST, job_valid, job_ready, job_err, START, O_VALID, busy, done, timeout, eng_abort;
  logic [5:0] job_h0, job_v0, H0, V0;
  logic [3:0] job_sw, job_sh, SW, SH;
  logic [1:0] done_id;
  logic [2:0] fifo_cnt;
  int n_chk = 0, n_fail = 0, start_n = 0, done_n = 0, d0, i;
  logic [1:0] ids[$];
  logic [19:0] pars[$];
  interp_scheduler dut (
    .clk(clk), .RST(RST), .job_valid(job_valid), .job_ready(job_ready),
    .job_h0(job_h0), .job_v0(job_v0), .job_sw(job_sw), .job_sh(job_sh),
    .job_err(job_err), .START(START), .H0(H0), .V0(V0), .SW(SW), .SH(SH),
    .O_VALID(O_VALID), .busy(busy), .done(done), .done_id(done_id),
    .fifo_cnt(fifo_cnt), .timeout(timeout), .eng_abort(eng_abort)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (START) begin start_n++; pars.push_back({H0, V0, SW, SH}); end
    if (done) begin done_n++; ids.push_back(done_id); end
  end
  initial begin
    #2_000_000;
    $display("FAIL global_timeout obs=hang exp=finish");
    $fatal(1, "simulation time limit");
  end
  function automatic logic [31:0] outs();
    return {job_err, START, H0, V0, SW, SH, busy, done, done_id, fifo_cnt, timeout, eng_abort, job_ready};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic [5:0] h, input logic [5:0] v, input logic [3:0] w, input logic [3:0] hh);
    job_h0 = h; job_v0 = v; job_sw = w; job_sh = hh; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask
  initial begin
    RST = 1'b1; job_valid = 1'b0; job_h0 = '0; job_v0 = '0; job_sw = '0; job_sh = '0; O_VALID = 1'b0;
    tick();
    chk("reset_outs", outs(), 32'h1);
    tick();
    RST = 1'b0;
    push(6'd0, 6'd0, 4'd0, 4'd4);
    chk("err_sw0", job_err, 1);
    chk("cnt_rej0", fifo_cnt, 0);
    push(6'd62, 6'd0, 4'd4, 4'd4);
    chk("err_h0", job_err, 1);
    chk("cnt_rej1", fifo_cnt, 0);
    tick();
    chk("err_clr", job_err, 0);
    repeat (3) tick();
    chk("no_start_rej", start_n, 0);
    chk("idle_rej", busy, 0);
    push(6'd0, 6'd0, 4'd4, 4'd4);
    chk("err_ok", job_err, 0);
    chk("cnt_one", fifo_cnt, 1);
    tick();
    chk("start36", START, 1);
    chk("pars36", {H0, V0, SW, SH}, {6'd0, 6'd0, 4'd4, 4'd4});
    chk("cnt_pop", fifo_cnt, 0);
    O_VALID = 1'b1;
    tick();
    chk("start_pulse", START, 0);
    repeat (255) tick();
    chk("not_early", done, 0);
    tick();
    O_VALID = 1'b0;
    chk("done36", {done, done_id, busy}, 4'b1001);
    tick();
    chk("done_once", {done, busy}, 2'b00);
    chk("starts36", start_n, 1);
    push(6'd1, 6'd1, 4'd2, 4'd2);
    tick();
    O_VALID = 1'b1;
    tick();
    repeat (127) tick();
    push(6'd2, 6'd2, 4'd2, 4'd2);
    chk("pre_rst_cnt", fifo_cnt, 1);
    d0 = done_n;
    #2 RST = 1'b1;
    #1 chk("rst_outs", outs(), 32'h1);
    chk("pre_rst_starts", start_n, 2);
    tick();
    RST = 1'b0;
    O_VALID = 1'b0;
    repeat (5) tick();
    chk("rst_nodone", done_n, d0);
    chk("rst_nostart", start_n, 2);
    chk("rst_empty", fifo_cnt, 0);
    ids.delete();
    pars.delete();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rdy%0d", k), job_ready, 1);
      push(6'(k), 6'(2 * k), 4'(k + 1), 4'(k + 2));
    end
    chk("full_rdy", job_ready, 0);
    chk("full_cnt", fifo_cnt, 4);
    O_VALID = 1'b1;
    for (i = 0; i < 2000 && ids.size() < 5; i++) tick();
    O_VALID = 1'b0;
    chk("dones5", ids.size(), 5);
    if (ids.size() == 5 && pars.size() == 5)
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("id%0d", k), ids[k], k % 4);
        chk($sformatf("par%0d", k), pars[k], {6'(k), 6'(2 * k), 4'(k + 1), 4'(k + 2)});
      end
    repeat (3) tick();
    ids.delete();
    push(6'd0, 6'd0, 4'd1, 4'd1);
    tick();
    tick();
    push(6'd3, 6'd3, 4'd1, 4'd1);
    push(6'd4, 6'd4, 4'd1, 4'd1);
    chk("cnt_two", fifo_cnt, 2);
`ifndef INTERP_SCHED_TIMEOUT_EN
    repeat (100) tick();
    chk("no_wdog", {timeout, eng_abort, busy}, 3'b001);
`endif
    O_VALID = 1'b1;
    for (i = 0; i < 400 && !done; i++) tick();
    O_VALID = 1'b0;
    chk("done_a", done, 1);
    tick();
    chk("idle_cnt", {busy, fifo_cnt}, 4'd2);
    job_h0 = 6'd5; job_v0 = 6'd5; job_sw = 4'd1; job_sh = 4'd1; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    chk("pushpop_cnt", fifo_cnt, 2);
    chk("pushpop_start", START, 1);
    O_VALID = 1'b1;
    for (i = 0; i < 1200 && ids.size() < 4; i++) tick();
    O_VALID = 1'b0;
    chk("dones4", ids.size(), 4);
    if (ids.size() == 4) chk("ids39", {ids[0], ids[1], ids[2], ids[3]}, 8'b01_10_11_00);
    repeat (3) tick();
`ifdef INTERP_SCHED_TIMEOUT_EN
    push(6'd0, 6'd0, 4'd1, 4'd1);
    tick();
    O_VALID = 1'b1;
    tick();
    repeat (99) tick();
    job_h0 = 6'd7; job_v0 = 6'd7; job_sw = 4'd2; job_sh = 4'd2; job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    O_VALID = 1'b0;
    d0 = done_n;
    for (i = 1; i < 200; i++) begin
      tick();
      if (timeout) break;
    end
    chk("wdog_delay", i, 64);
    chk("wdog_pulse", {timeout, eng_abort, done}, 3'b110);
    tick();
    chk("wdog_once", timeout, 0);
    tick();
    chk("wdog_next_start", {START, H0}, {1'b1, 6'd7});
    chk("wdog_nodone", done_n, d0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
